// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART frame packer: FSM state encodings, default
// sync header bytes and the width and reload value of the byte-pacing counter.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_H0   = 3'd1,
        ST_H1   = 3'd2,
        ST_LEN  = 3'd3,
        ST_PAY  = 3'd4,
        ST_CHK  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [7:0] HDR0_DEF = 8'hAA;
    localparam logic [7:0] HDR1_DEF = 8'h55;

    // After each strobe the transmitter's idle flag is ignored for this many
    // cycles, because the transmitter needs one cycle to drop tx_idle.
    localparam int                HOLD_W    = 2;
    localparam logic [HOLD_W-1:0] HOLD_INIT = 2'd2;

endpackage

// File: rtl/uart_frame_packer_if.sv
// -----------------------------------------------------------------------------
// uart_frame_packer_if
// Groups the upstream byte stream and the transmitter byte port.
//   s_data/s_valid/s_ready : upstream payload bytes into the packer FIFO
//   tx_idle                : transmitter ready for a new byte
//   tx_wr_en/tx_din        : write strobe and byte to the transmitter
// Modport master is the packer side; slave is the surrounding environment
// (upstream source plus transmitter).
// -----------------------------------------------------------------------------
interface uart_frame_packer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       tx_idle;
    logic       tx_wr_en;
    logic [7:0] tx_din;

    modport master (
        input  s_data,
        input  s_valid,
        input  tx_idle,
        output s_ready,
        output tx_wr_en,
        output tx_din
    );

    modport slave (
        output s_data,
        output s_valid,
        output tx_idle,
        input  s_ready,
        input  tx_wr_en,
        input  tx_din
    );
endinterface

// File: rtl/uart_byte_fifo.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo
// Byte FIFO, depth 2**AW, first-word fall-through (rdata shows the head
// whenever the FIFO is not empty). Push while full and pop while empty are
// ignored; a simultaneous push and pop keeps the count unchanged.
// Ports:
//   clk_50m, rst : clock, synchronous active-high reset (flushes the FIFO)
//   wr, wdata    : push request and data
//   rd, rdata    : pop request and head data
//   count        : occupancy 0..2**AW
//   full, empty  : occupancy flags derived from the registered count
// -----------------------------------------------------------------------------
module uart_byte_fifo #(
    parameter int AW = 6
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        wr,
    input  logic [7:0]  wdata,
    input  logic        rd,
    output logic [7:0]  rdata,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);
    localparam int            DEPTH     = 1 << AW;
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_reg [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;
    assign rdata = mem_reg[rd_ptr_reg];

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk_50m) begin
        if (wr_en) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide so they wrap modulo depth by themselves.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/uart_frame_packer.sv
// -----------------------------------------------------------------------------
// uart_frame_packer
// Buffers payload bytes and feeds them to a byte-serial UART transmitter as
// frames: HDR0, HDR1, LEN, LEN payload bytes, optional checksum. A frame only
// starts once a complete payload sits in the FIFO, so it never underruns.
// Every byte is paced on tx_idle, with a short hold after each strobe to
// cover the transmitter's one-cycle idle->busy lag.
// Ports:
//   clk_50m    : clock
//   rst        : synchronous active-high reset; aborts any frame, flushes FIFO
//   bus        : uart_frame_packer_if.master (upstream stream + transmitter port)
//   frame_busy : high from the first header strobe until the frame is finished
//   ovf        : sticky, a byte was offered while the FIFO was full
// Build option:
//   UART_PACK_CHKSUM_EN : when defined, a checksum byte (8-bit sum of LEN and
//                         payload) follows the payload; otherwise it is omitted.
// -----------------------------------------------------------------------------
module uart_frame_packer
    import uart_pkg::*;
#(
    parameter int         FRAME_LEN = 16,
    parameter int         FIFO_AW   = 6,
    parameter logic [7:0] HDR0      = HDR0_DEF,
    parameter logic [7:0] HDR1      = HDR1_DEF
) (
    input  logic                clk_50m,
    input  logic                rst,
    uart_frame_packer_if.master bus,
    output logic                frame_busy,
    output logic                ovf
);
    localparam logic [7:0]       LEN_BYTE  = 8'(FRAME_LEN);
    localparam logic [7:0]       LAST_IDX  = 8'(FRAME_LEN - 1);
    localparam logic [FIFO_AW:0] START_CNT = (FIFO_AW+1)'(FRAME_LEN);

    state_t             state_reg;
    state_t             state_next;
    logic [HOLD_W-1:0]  hold_reg;
    logic [7:0]         byte_cnt_reg;
    logic [7:0]         tx_din_reg;
    logic               ovf_reg;
    logic               issue;
    logic [7:0]         byte_sel;
    logic               frame_start;

    logic [7:0]         fifo_rdata;
    logic [FIFO_AW:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_rd;

`ifdef UART_PACK_CHKSUM_EN
    logic [7:0]         csum_reg;
`endif

    uart_byte_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk_50m (clk_50m),
        .rst     (rst),
        .wr      (bus.s_valid),
        .wdata   (bus.s_data),
        .rd      (fifo_rd),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register
    always_ff @(posedge clk_50m) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (frame_start) state_next = ST_H0;
            ST_H0:   if (issue) state_next = ST_H1;
            ST_H1:   if (issue) state_next = ST_LEN;
            ST_LEN:  if (issue) state_next = ST_PAY;
            ST_PAY: begin
                if (issue && byte_cnt_reg == LAST_IDX) begin
`ifdef UART_PACK_CHKSUM_EN
                    state_next = ST_CHK;
`else
                    state_next = ST_DONE;
`endif
                end
            end
            ST_CHK:  if (issue) state_next = ST_DONE;
            // The single IDLE cycle that follows guarantees a gap between frames.
            ST_DONE: if (hold_reg == '0 && bus.tx_idle) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: byte selection, strobe, FIFO pop, busy flag
    always_comb begin
        byte_sel    = 8'h00;
        issue       = 1'b0;
        frame_start = (fifo_count >= START_CNT) && bus.tx_idle;
        case (state_reg)
            ST_H0:   byte_sel = HDR0;
            ST_H1:   byte_sel = HDR1;
            ST_LEN:  byte_sel = LEN_BYTE;
            ST_PAY:  byte_sel = fifo_rdata;
`ifdef UART_PACK_CHKSUM_EN
            ST_CHK:  byte_sel = csum_reg;
`endif
            default: byte_sel = 8'h00;
        endcase
        if (state_reg inside {ST_H0, ST_H1, ST_LEN, ST_PAY, ST_CHK}) begin
            issue = (hold_reg == '0) && bus.tx_idle
                    && !(state_reg == ST_PAY && fifo_empty);
        end
        bus.tx_wr_en = issue;
        // Byte is presented combinationally on the strobe cycle, then held.
        bus.tx_din   = issue ? byte_sel : tx_din_reg;
        bus.s_ready  = !fifo_full;
        fifo_rd      = issue && (state_reg == ST_PAY);
        frame_busy   = (state_reg != ST_IDLE) && ((state_reg != ST_H0) || issue);
        ovf          = ovf_reg;
    end

    // Datapath: pacing hold, payload counter, held tx byte, overflow flag
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            hold_reg     <= '0;
            byte_cnt_reg <= 8'h00;
            tx_din_reg   <= 8'h00;
            ovf_reg      <= 1'b0;
        end else begin
            if (issue)               hold_reg <= HOLD_INIT;
            else if (hold_reg != '0) hold_reg <= hold_reg - 1'b1;

            if (issue) tx_din_reg <= byte_sel;

            if (state_reg == ST_IDLE && frame_start)
                byte_cnt_reg <= 8'h00;
            else if (fifo_rd)
                byte_cnt_reg <= byte_cnt_reg + 8'd1;

            if (bus.s_valid && fifo_full) ovf_reg <= 1'b1;
        end
    end

`ifdef UART_PACK_CHKSUM_EN
    // Checksum covers LEN and payload only; headers are excluded.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            csum_reg <= 8'h00;
        end else if (state_reg == ST_IDLE && frame_start) begin
            csum_reg <= 8'h00;
        end else if (issue && state_reg == ST_LEN) begin
            csum_reg <= csum_reg + LEN_BYTE;
        end else if (fifo_rd) begin
            csum_reg <= csum_reg + fifo_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_uart_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_packer
// Scoreboard bench for uart_frame_packer (FRAME_LEN=4, FIFO_AW=2). Stimulus
// pushes the expected transmitter bytes into exp_q; a monitor pops and compares
// on every tx_wr_en strobe. A simple transmitter model drops tx_idle one cycle
// after each strobe and stays busy for 10 cycles.
// -----------------------------------------------------------------------------
module tb_uart_frame_packer;
    localparam int FRAME_LEN = 4;
    localparam int FIFO_AW   = 2;
`ifdef UART_PACK_CHKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif
    localparam int FRAME_BYTES = CHK_ON ? FRAME_LEN + 4 : FRAME_LEN + 3;

    logic clk_50m = 1'b0;
    logic rst;
    logic frame_busy;
    logic ovf;

    uart_frame_packer_if bus ();

    uart_frame_packer #(
        .FRAME_LEN (FRAME_LEN),
        .FIFO_AW   (FIFO_AW),
        .HDR0      (8'hAA),
        .HDR1      (8'h55)
    ) dut (
        .clk_50m    (clk_50m),
        .rst        (rst),
        .bus        (bus),
        .frame_busy (frame_busy),
        .ovf        (ovf)
    );

    always #5 clk_50m = ~clk_50m;

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         strobe_cnt = 0;
    logic [7:0] exp_q[$];
    bit         tx_block   = 1'b0;
    bit         tx_seen    = 1'b0;
    bit         tx_lag     = 1'b0;
    int         tx_busy    = 0;
    bit         mon_prev_wr = 1'b0;

    // Transmitter model, updated 1 time unit after each rising edge.
    initial begin
        bus.tx_idle = 1'b1;
        forever begin
            @(posedge clk_50m);
            #1;
            if (tx_busy > 0) tx_busy--;
            if (tx_lag) begin
                tx_busy = 10;
                tx_lag  = 1'b0;
            end
            if (tx_seen) begin
                tx_lag  = 1'b1;
                tx_seen = 1'b0;
            end
            bus.tx_idle = (tx_busy == 0) && !tx_block;
        end
    end

    // Monitor: samples on the falling edge, pops and compares each strobe.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk_50m);
            if (rst) begin
                mon_prev_wr = 1'b0;
            end else begin
                if (bus.tx_wr_en) begin
                    strobe_cnt++;
                    tx_seen = 1'b1;
                    n_checks++;
                    if (mon_prev_wr) begin
                        n_fail++;
                        $display("FAIL wr_width: tx_wr_en high for 2 cycles, required 1");
                    end
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_strobe: got tx_din=%02h, required no strobe", bus.tx_din);
                    end else begin
                        e = exp_q.pop_front();
                        $display("strobe %0d: tx_din=%02h expected=%02h", strobe_cnt, bus.tx_din, e);
                        if (bus.tx_din !== e) begin
                            n_fail++;
                            $display("FAIL tx_byte: actual=%02h required=%02h", bus.tx_din, e);
                        end
                    end
                end
                mon_prev_wr = bus.tx_wr_en;
            end
        end
    end

    task automatic wait_clk();
        @(posedge clk_50m);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] b);
        $display("push %02h s_ready=%0b", b, bus.s_ready);
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        wait_clk();
        bus.s_valid = 1'b0;
    endtask

    task automatic exp_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input logic [7:0] cs);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h04);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        if (CHK_ON) exp_q.push_back(cs);
    endtask

    task automatic wait_done(input string name);
        int budget;
        budget = 600;
        while ((exp_q.size() != 0 || frame_busy) && budget > 0) begin
            wait_clk();
            budget--;
        end
        check({name, "_timeout"}, 32'(budget > 0), 32'd1);
        check({name, "_strobes"}, 32'(strobe_cnt), 32'(FRAME_BYTES));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        bit bad;

        // Reset held 3 cycles with s_valid asserted.
        rst         = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h5A;
        repeat (3) wait_clk();
        check("rst_tx_wr_en",   32'(bus.tx_wr_en), 32'd0);
        check("rst_tx_din",     32'(bus.tx_din),   32'h00);
        check("rst_frame_busy", 32'(frame_busy),   32'd0);
        check("rst_ovf",        32'(ovf),          32'd0);
        check("rst_s_ready",    32'(bus.s_ready),  32'd1);
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        repeat (10) wait_clk();
        check("rst_fifo_empty_no_frame", 32'(strobe_cnt), 32'd0);

        // Nominal frame.
        strobe_cnt = 0;
        exp_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0E);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_done("nominal");

        // Checksum wrap.
        strobe_cnt = 0;
        exp_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
        push(8'hFF); push(8'hFF); push(8'hFF); push(8'hFF);
        wait_done("csum_wrap");

        // Partial payload: nothing happens until the 4th byte.
        strobe_cnt = 0;
        push(8'h10); push(8'h11); push(8'h12);
        bad = 1'b0;
        repeat (20) begin
            wait_clk();
            if (frame_busy || bus.tx_wr_en) bad = 1'b1;
        end
        check("partial_idle", 32'(bad), 32'd0);
        check("partial_no_strobe", 32'(strobe_cnt), 32'd0);
        exp_frame(8'h10, 8'h11, 8'h12, 8'h13, 8'h4A);
        push(8'h13);
        wait_clk();
        check("start_latency_wr_en", 32'(bus.tx_wr_en), 32'd1);
        check("start_latency_din",   32'(bus.tx_din),   32'hAA);
        check("start_frame_busy",    32'(frame_busy),   32'd1);
        wait_done("partial");

        // Full FIFO with transmitter held busy.
        tx_block = 1'b1;
        repeat (3) wait_clk();
        strobe_cnt = 0;
        push(8'h21); push(8'h22); push(8'h23);
        check("full_ready_before", 32'(bus.s_ready), 32'd1);
        push(8'h24);
        check("full_ready_low", 32'(bus.s_ready), 32'd0);
        check("full_ovf_clear", 32'(ovf), 32'd0);
        push(8'h25);
        check("full_ovf_set", 32'(ovf), 32'd1);
        check("full_ready_still_low", 32'(bus.s_ready), 32'd0);
        exp_frame(8'h21, 8'h22, 8'h23, 8'h24, 8'h8E);
        tx_block = 1'b0;
        wait_done("full");
        check("ovf_sticky", 32'(ovf), 32'd1);
        check("full_ready_after", 32'(bus.s_ready), 32'd1);

        // Reset after 2 payload strobes.
        strobe_cnt = 0;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        push(8'h31); push(8'h32); push(8'h33); push(8'h34);
        budget = 600;
        while (strobe_cnt < 5 && budget > 0) begin
            wait_clk();
            budget--;
        end
        check("midrst_reach_pay_timeout", 32'(budget > 0), 32'd1);
        rst = 1'b1;
        repeat (2) wait_clk();
        rst = 1'b0;
        repeat (40) wait_clk();
        check("midrst_no_more_strobes", 32'(strobe_cnt), 32'd5);
        check("midrst_frame_busy", 32'(frame_busy), 32'd0);
        check("midrst_ovf_cleared", 32'(ovf), 32'd0);
        check("midrst_s_ready", 32'(bus.s_ready), 32'd1);
        strobe_cnt = 0;
        exp_frame(8'h41, 8'h42, 8'h43, 8'h44, 8'h0E);
        push(8'h41); push(8'h42); push(8'h43); push(8'h44);
        wait_done("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
